// File: rtl/clut_pkg.sv
// Shared sizing and FSM encoding for the CLUT write-side loader.
package clut_pkg;

   localparam int unsigned COLOR_BITS    = 4;
   localparam int unsigned NUM_OF_COLORS = 16;
   localparam int unsigned LINE_SIZE     = 3;
   localparam int unsigned W             = COLOR_BITS * LINE_SIZE;
   localparam int unsigned ENTRY_BYTES   = (W + 7) / 8;

   typedef enum logic [2:0] {
      StIdle,
      StRecv,
      StWrite,
      StCsum,
      StDone
   } state_e;

endpackage

// File: rtl/clut_loader_if.sv
// Byte-stream valid/ready handshake feeding the CLUT loader.
interface clut_loader_if;

   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/clut_entry_assembler.sv
// Collects big-endian payload bytes into one W-bit palette entry.
module clut_entry_assembler
   import clut_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         push,
   input  logic [7:0]   byte_in,
   output logic [W-1:0] word,
   output logic         last_byte
);

   localparam int unsigned HiW  = W - 8;
   localparam int unsigned IdxW = (ENTRY_BYTES > 1) ? $clog2(ENTRY_BYTES) : 1;

   logic [HiW-1:0]  hi_q;
   logic [IdxW-1:0] idx_q;

   // The word already includes the byte being presented, so the last byte needs no extra cycle.
   assign word      = {hi_q, byte_in};
   assign last_byte = (idx_q == IdxW'(ENTRY_BYTES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         idx_q <= '0;
      end else if (clear) begin
         idx_q <= '0;
      end else if (push) begin
         hi_q  <= word[HiW-1:0];
         idx_q <= last_byte ? '0 : idx_q + 1'b1;
      end
   end

endmodule

// File: rtl/clut_loader.sv
// CLUT write-side loader: turns a byte stream into single-cycle CLUT write strobes.
// Define CLUT_LOADER_CHECKSUM_EN to require a trailing checksum byte that flags err on mismatch.
module clut_loader
   import clut_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [COLOR_BITS-1:0] start_addr,
   input  logic [COLOR_BITS-1:0] count,
   clut_loader_if.slave          in_bus,
   output logic                  clut_we,
   output logic [COLOR_BITS-1:0] clut_addr,
   output logic [W-1:0]          clut_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned RemW = COLOR_BITS + 1;

   state_e                state_q, state_d;
   logic [COLOR_BITS-1:0] addr_q;
   logic [W-1:0]          data_q;
   logic [RemW-1:0]       rem_q;
   logic                  ready, load, accept, push, last_byte, bad;
   logic [W-1:0]          word;

   assign load            = (state_q == StIdle) && start;
   assign accept          = in_bus.in_valid && ready;
   assign push            = accept && (state_q == StRecv);
   assign in_bus.in_ready = ready;
   assign clut_addr       = addr_q;
   assign clut_data       = data_q;

   clut_entry_assembler u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (load),
      .push      (push),
      .byte_in   (in_bus.in_data),
      .word      (word),
      .last_byte (last_byte)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRecv;
         StRecv:  if (accept && last_byte) state_d = StWrite;
         StWrite: begin
            if (rem_q == RemW'(1)) begin
`ifdef CLUT_LOADER_CHECKSUM_EN
               state_d = StCsum;
`else
               state_d = StDone;
`endif
            end else begin
               state_d = StRecv;
            end
         end
         StCsum:  if (in_bus.in_valid) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ready   = (state_q == StRecv) || (state_q == StCsum);
      clut_we = (state_q == StWrite);
      busy    = (state_q != StIdle);
      done    = (state_q == StDone);
      err     = done && bad;
   end

   // clut_data is captured on the last byte so it stays frozen while the next entry streams in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         data_q <= '0;
         rem_q  <= '0;
      end else begin
         if (load) begin
            addr_q <= start_addr;
            rem_q  <= (count == '0) ? RemW'(NUM_OF_COLORS) : {1'b0, count};
         end
         if (push && last_byte) begin
            data_q <= word;
         end
         if (state_q == StWrite) begin
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
         end
      end
   end

`ifdef CLUT_LOADER_CHECKSUM_EN
   logic [7:0] sum_q;
   logic       bad_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         bad_q <= 1'b0;
      end else if (load) begin
         sum_q <= '0;
         bad_q <= 1'b0;
      end else if (push) begin
         sum_q <= sum_q + in_bus.in_data;
      end else if (accept && (state_q == StCsum)) begin
         bad_q <= (sum_q + in_bus.in_data) != 8'h00;
      end
   end

   assign bad = bad_q;
`else
   assign bad = 1'b0;
`endif

endmodule

// File: tb/tb_clut_loader.sv
// Randomized bench for clut_loader against a queue-based model of the expected CLUT writes.
module tb_clut_loader;
   import clut_pkg::*;

   typedef struct packed {
      logic [COLOR_BITS-1:0] addr;
      logic [W-1:0]          data;
   } wr_t;

`ifdef CLUT_LOADER_CHECKSUM_EN
   localparam bit CsumEn = 1'b1;
`else
   localparam bit CsumEn = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  start = 1'b0;
   logic [COLOR_BITS-1:0] start_addr = '0;
   logic [COLOR_BITS-1:0] count = '0;
   logic                  clut_we, busy, done, err;
   logic [COLOR_BITS-1:0] clut_addr;
   logic [W-1:0]          clut_data;

   clut_loader_if in_bus ();

   clut_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .count      (count),
      .in_bus     (in_bus),
      .clut_we    (clut_we),
      .clut_addr  (clut_addr),
      .clut_data  (clut_data),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_err = 0;
   wr_t        exp_q[$];
   logic [7:0] tx_q[$];
   int         pay_left = 0;
   logic [7:0] sum_m = '0;
   bit         mon_en = 1'b0;
   bit         we_due, done_due, err_due, nxt_we, nxt_done, nxt_err;
   wr_t        mon_e;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Every negedge: compare strobes against what the accepted bytes so far imply.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            we_due = 0; done_due = 0; err_due = 0;
         end else begin
            check_eq("we_timing", 32'(clut_we), 32'(we_due));
            check_eq("done_timing", 32'(done), 32'(done_due));
            check_eq("err", 32'(err), 32'(err_due));
            nxt_we = 0; nxt_done = 0; nxt_err = 0;
            if (clut_we) begin
               check_eq("ready_in_write", 32'(in_bus.in_ready), 32'd0);
               check_eq("write_expected", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  mon_e = exp_q.pop_front();
                  check_eq("clut_addr", 32'(clut_addr), 32'(mon_e.addr));
                  check_eq("clut_data", 32'(clut_data), 32'(mon_e.data));
                  if (exp_q.size() == 0 && !CsumEn) nxt_done = 1;
               end
            end
            if (in_bus.in_valid && in_bus.in_ready) begin
               if (pay_left > 0) begin
                  pay_left--;
                  sum_m = sum_m + in_bus.in_data;
                  if (pay_left % 2 == 0) nxt_we = 1;
               end else if (CsumEn) begin
                  nxt_done = 1;
                  nxt_err  = (8'(sum_m + in_bus.in_data) != 8'h00);
               end
            end
            we_due = nxt_we; done_due = nxt_done; err_due = nxt_err;
         end
      end
   end

   task automatic check_reset_outputs();
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_in_ready", 32'(in_bus.in_ready), 32'd0);
      check_eq("rst_clut_we", 32'(clut_we), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("rst_clut_addr", 32'(clut_addr), 32'd0);
      check_eq("rst_clut_data", 32'(clut_data), 32'd0);
   endtask

   task automatic fill_random(input int n);
      tx_q.delete();
      repeat (n) tx_q.push_back(8'($urandom));
   endtask

   // Entry i lands at (a+i) mod 16; data = (byte0 mod 16)*256 + byte1.
   task automatic expect_writes(input logic [3:0] a, input logic [3:0] c, output int n);
      wr_t e;
      n = (c == 4'd0) ? NUM_OF_COLORS : int'(c);
      for (int i = 0; i < n; i++) begin
         e.addr = 4'((int'(a) + i) % NUM_OF_COLORS);
         e.data = 12'((int'(tx_q[2*i]) % 16) * 256 + int'(tx_q[2*i+1]));
         exp_q.push_back(e);
      end
      pay_left = 2 * n;
      sum_m    = '0;
   endtask

   task automatic pulse_start(input logic [3:0] a, input logic [3:0] c);
      in_bus.in_valid = 1'b0;
      start = 1'b1; start_addr = a; count = c;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall);
      bit took;
      took = 0;
      if (stall > 0) begin
         in_bus.in_valid = 1'b0;
         repeat (stall) begin @(posedge clk); #1; end
      end
      in_bus.in_valid = 1'b1;
      in_bus.in_data  = b;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_bus.in_ready) begin took = 1; break; end
      end
      @(posedge clk); #1;
      check_eq("byte_taken", 32'(took), 32'd1);
   endtask

   task automatic finish_load();
      bit seen;
      seen = 0;
      in_bus.in_valid = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (done) begin seen = 1; break; end
      end
      check_eq("done_seen", 32'(seen), 32'd1);
      @(negedge clk);
      check_eq("busy_after_done", 32'(busy), 32'd0);
      check_eq("writes_left", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic run_load(input logic [3:0] a, input logic [3:0] c, input bit stalls,
                           input bit poke, input bit bad_sum);
      int         n;
      logic [7:0] s;
      expect_writes(a, c, n);
      pulse_start(a, c);
      check_eq("busy_during_load", 32'(busy), 32'd1);
      for (int j = 0; j < 2 * n; j++) begin
         send_byte(tx_q[j], (stalls && (j % 2 == 1)) ? 2 : 0);
         if (poke && j == 3) pulse_start(~a, c + 4'd5);
      end
`ifdef CLUT_LOADER_CHECKSUM_EN
      s = '0;
      foreach (tx_q[k]) s = s + tx_q[k];
      s = -s;
      s = s + {7'd0, bad_sum};
      send_byte(s, 0);
`else
      s = {7'd0, bad_sum};
      if (s != 8'd0) $display("note: checksum corruption requested without checksum build");
`endif
      finish_load();
   endtask

   initial begin : main
      int         n;
      logic [3:0] a, c;
      in_bus.in_valid = 1'b0;
      in_bus.in_data  = '0;
      #3;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;

      // Full palette, first entry 0F 00 -> F00
      fill_random(32);
      tx_q[0] = 8'h0F; tx_q[1] = 8'h00;
      run_load(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

      // Address wrap 14,15,0
      tx_q.delete();
      tx_q.push_back(8'h01); tx_q.push_back(8'h23); tx_q.push_back(8'h04);
      tx_q.push_back(8'h56); tx_q.push_back(8'h07); tx_q.push_back(8'h89);
      run_load(4'd14, 4'd3, 1'b0, 1'b0, 1'b0);

      // Upper nibble of byte 0 ignored
      tx_q.delete();
      tx_q.push_back(8'hF1); tx_q.push_back(8'h23);
      run_load(4'd7, 4'd1, 1'b0, 1'b0, 1'b0);

      // Stalls before every second byte
      fill_random(8);
      run_load(4'(4'($urandom)), 4'd4, 1'b1, 1'b0, 1'b0);

      // Start while busy is ignored
      fill_random(10);
      run_load(4'd3, 4'd5, 1'b0, 1'b1, 1'b0);

      // Reset after byte 0 of entry 2
      fill_random(8);
      expect_writes(4'd5, 4'd4, n);
      pulse_start(4'd5, 4'd4);
      for (int j = 0; j < 5; j++) send_byte(tx_q[j], 0);
      in_bus.in_valid = 1'b0;
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs();
      check_eq("writes_before_reset", 32'(exp_q.size()), 32'd2);
      exp_q.delete();
      pay_left = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;
      fill_random(6);
      run_load(4'd9, 4'd3, 1'b0, 1'b0, 1'b0);

      // Random loads
      for (int k = 0; k < 6; k++) begin
         a = 4'($urandom_range(0, 15));
         c = 4'($urandom_range(0, 15));
         n = (c == 4'd0) ? NUM_OF_COLORS : int'(c);
         fill_random(2 * n);
         run_load(a, c, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

`ifdef CLUT_LOADER_CHECKSUM_EN
      // Good checksum 0xDC, then bad 0xDD
      tx_q.delete();
      tx_q.push_back(8'h01); tx_q.push_back(8'h23);
      run_load(4'd2, 4'd1, 1'b0, 1'b0, 1'b0);
      run_load(4'd2, 4'd1, 1'b0, 1'b0, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
